logic_op_arbiter: RTL and testbench

Shares one registered logic-operation unit (AND/OR/NOR/NAND/XOR on WIDTH-bit operands) between N_REQ requesters. Requests are granted round-robin through valid/ready handshakes; one operation is executed at a time, and its result is returned on a single response channel tagged with the requester index. The block sits between the requester-side control logic and the shared bitwise datapath, replacing per-requester gate instances.

---
 rtl/logic_op_pkg.sv | 16 +
 rtl/logic_alu.sv | 27 ++
 rtl/logic_op_arbiter.sv | 145 ++++++++++++++
 tb/tb_logic_op_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/logic_op_pkg.sv
// Shared definitions for the logic-operation arbiter: opcode values and FSM state encoding.
package logic_op_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/logic_alu.sv
// Purely combinational bitwise unit; opcodes outside AND..XOR yield zero data and err=1.
module logic_alu
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             err
);

    always_comb begin
        y   = '0;
        err = 1'b0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NOR:  y = ~(a | b);
            OP_NAND: y = ~(a & b);
            OP_XOR:  y = a ^ b;
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one registered logic_alu among N_REQ requesters.
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// req_ready is offered only in IDLE, rsp_valid holds with stable payload until rsp_ready.
module logic_op_arbiter
    import logic_op_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [3*N_REQ-1:0]     req_op,
    input  logic [WIDTH*N_REQ-1:0] req_a,
    input  logic [WIDTH*N_REQ-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [WIDTH-1:0]       rsp_data,
    output logic                   rsp_err,
    output logic                   busy
);

    state_t            state;
    state_t            state_next;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant;
    logic              grant_found;
    logic [ID_W-1:0]   hi_grant;
    logic              hi_found;
    logic [ID_W-1:0]   lo_grant;
    logic              accept;
    logic [2:0]        sel_op;
    logic [WIDTH-1:0]  sel_a;
    logic [WIDTH-1:0]  sel_b;
    logic [2:0]        op_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [ID_W-1:0]   id_q;
    logic [WIDTH-1:0]  alu_y;
    logic              alu_err;

    // Round-robin: lowest valid index at or above rr_ptr, else lowest valid index overall.
    always_comb begin
        hi_grant    = '0;
        hi_found    = 1'b0;
        lo_grant    = '0;
        grant_found = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_grant    = i[ID_W-1:0];
                grant_found = 1'b1;
                if (i >= int'(rr_ptr)) begin
                    hi_grant = i[ID_W-1:0];
                    hi_found = 1'b1;
                end
            end
        end
        grant = hi_found ? hi_grant : lo_grant;
    end

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (int'(grant) == i) begin
                sel_op = req_op[3*i +: 3];
                sel_a  = req_a[WIDTH*i +: WIDTH];
                sel_b  = req_b[WIDTH*i +: WIDTH];
            end
        end
    end

    assign accept = (state == ST_IDLE) && grant_found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = ST_EXEC;
            ST_EXEC: state_next = ST_RESP;
            ST_RESP: if (rsp_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant] = 1'b1;
        end
        rsp_valid = (state == ST_RESP);
        busy      = (state != ST_IDLE);
    end

    logic_alu #(.WIDTH(WIDTH)) u_alu (
        .op  (op_q),
        .a   (a_q),
        .b   (b_q),
        .y   (alu_y),
        .err (alu_err)
    );

    // Operands latch on accept; the response registers load only in EXEC and then hold through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= sel_op;
                a_q  <= sel_a;
                b_q  <= sel_b;
                id_q <= grant;
                if (int'(grant) == N_REQ - 1) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= grant + 1'b1;
                end
            end
            if (state == ST_EXEC) begin
                rsp_id   <= id_q;
                rsp_data <= alu_y;
                rsp_err  <= alu_err;
            end
        end
    end

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed plus randomized bench for logic_op_arbiter against a behavioural arbitration/result model.
module tb_logic_op_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [3*N-1:0] req_op;
    logic [W*N-1:0] req_a;
    logic [W*N-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_data;
    logic           rsp_err;
    logic           busy;

    int n_checks;
    int n_fail;
    int model_ptr;
    logic [2:0]   op_t[N];
    logic [W-1:0] a_t[N];
    logic [W-1:0] b_t[N];

    logic_op_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Rotating scan from the pointer: the first valid requester met wins.
    function automatic int pick(input logic [N-1:0] v, input int ptr);
        int c;
        for (int k = 0; k < N; k++) begin
            c = (ptr + k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] ref_y(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~(a | b);
            3'd3:    return ~(a & b);
            3'd4:    return a ^ b;
            default: return '0;
        endcase
    endfunction

    task automatic set_req(input int i, input logic [2:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b);
        op_t[i] = op;
        a_t[i]  = a;
        b_t[i]  = b;
        req_op[3*i +: 3] = op;
        req_a[W*i +: W]  = a;
        req_b[W*i +: W]  = b;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_id"},    32'(rsp_id),    32'd0);
        check({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
        check({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    endtask

    task automatic do_reset();
        req_valid = '0;
        rsp_ready = 1'b1;
        rst_n     = 1'b0;
        #2;
        check_reset_outputs("reset");
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_ptr = 0;
    endtask

    // Called 1ns after a rising edge with the DUT in IDLE; walks one full transaction.
    task automatic run_one(input logic [N-1:0] vmask, input int stall);
        int           g;
        logic [W-1:0] exp_y;
        logic         exp_err;
        g = pick(vmask, model_ptr);
        req_valid = vmask;
        #1;
        check("grant", 32'(req_ready), 32'd1 << g);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        exp_y   = ref_y(op_t[g], a_t[g], b_t[g]);
        exp_err = (op_t[g] > 3'd4);
        rsp_ready = (stall == 0);
        @(posedge clk);
        #1;
        model_ptr = (g + 1) % N;
        check("exec_busy", 32'(busy), 32'd1);
        check("exec_req_ready", 32'(req_ready), 32'd0);
        check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_id", 32'(rsp_id), 32'(g));
        check("rsp_data", 32'(rsp_data), 32'(exp_y));
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_id", 32'(rsp_id), 32'(g));
            check("stall_data", 32'(rsp_data), 32'(exp_y));
            check("stall_err", 32'(rsp_err), 32'(exp_err));
            check("stall_req_ready", 32'(req_ready), 32'd0);
            check("stall_busy", 32'(busy), 32'd1);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("back_idle_valid", 32'(rsp_valid), 32'd0);
        check("back_idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        model_ptr = 0;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        rst_n     = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 3'd0, '0, '0);
        do_reset();

        // Single AND transaction on requester 0.
        set_req(0, 3'd0, 8'hF0, 8'h3C);
        run_one(4'b0001, 0);
        check("and_const", 32'(rsp_data), 32'h30);

        // All four requesters continuously valid after a fresh reset: grants 0,1,2,3,0.
        do_reset();
        set_req(0, 3'd1, 8'hA5, 8'h0F);
        set_req(1, 3'd2, 8'hA5, 8'h0F);
        set_req(2, 3'd3, 8'hA5, 8'h0F);
        set_req(3, 3'd4, 8'hA5, 8'h0F);
        for (int k = 0; k < 5; k++) run_one(4'b1111, 0);
        check("xor_ptr_after_wrap", 32'(model_ptr), 32'd1);

        // Illegal opcode on requester 2.
        set_req(2, 3'd6, 8'hFF, 8'hFF);
        run_one(4'b0100, 0);

        // Response stall of five cycles.
        set_req(3, 3'd4, 8'h5A, 8'h33);
        run_one(4'b1000, 5);

        // No requests: stays idle.
        req_valid = '0;
        #1;
        check("none_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        check("none_busy", 32'(busy), 32'd0);

        // Grant is recomputed when the granted requester drops valid before the edge.
        req_valid = 4'b1010;
        #1;
        check("pre_drop_grant", 32'(req_ready), 32'd1 << pick(4'b1010, model_ptr));
        run_one(4'b1010 & ~(4'b0001 << pick(4'b1010, model_ptr)), 0);

        // Reset during EXEC discards the operation and clears the pointer.
        set_req(1, 3'd0, 8'hFF, 8'hFF);
        req_valid = 4'b0010;
        @(posedge clk);
        #1;
        check("pre_rst_busy", 32'(busy), 32'd1);
        req_valid = '0;
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk);
        #1;
        check("rst_hold_valid", 32'(rsp_valid), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_valid", 32'(rsp_valid), 32'd0);
        model_ptr = 0;
        for (int i = 0; i < N; i++) set_req(i, 3'd1, 8'h11 << i, 8'h80);
        run_one(4'b1111, 0);

        // Randomized traffic.
        for (int it = 0; it < 60; it++) begin
            for (int i = 0; i < N; i++) begin
                set_req(i, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
            end
            run_one(4'($urandom_range(1, 15)), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
